// File: rtl/led_pkg.sv
// Shared constants and types for the LED fade driver.
package led_pkg;

  localparam int unsigned LED_N_LEDS   = 16;
  localparam int unsigned LED_PWM_BITS = 8;
  localparam int unsigned CLK_HZ       = 100_000_000;
  localparam int unsigned LED_PWM_DIV  = 16;
  localparam int unsigned LED_FADE_DIV = 390_625;

  typedef logic [LED_PWM_BITS-1:0] led_level_t;

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: level register with instant attack and linear decay, optional
// square-law gamma on the duty value, and the PWM comparator.
// Build option: define LED_FADE_GAMMA_EN for duty = (level*level) >> PWM_BITS.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = LED_PWM_BITS
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [PWM_BITS-1:0] i_target,
  input  logic                i_fade_tick,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_led,
  output logic                o_match
);

  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] duty;
  logic                led_q;

  // Attack beats decay; decay only moves toward the target, so it never undershoots.
  always_comb begin
    level_d = level_q;
    if (level_q < i_target) begin
      level_d = i_target;
    end else if ((level_q > i_target) && i_fade_tick) begin
      level_d = level_q - PWM_BITS'(1);
    end
  end

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_sq;
  assign level_sq = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};
  assign duty     = level_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign duty = level_q;
`endif

  // Level register and registered PWM output.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= (duty > i_pwm_cnt);
    end
  end

  assign o_led   = led_q;
  assign o_match = (level_q == i_target);

endmodule

// File: rtl/led_fade_driver.sv
// PWM LED driver with instant attack and linear decay per channel.
// Shared prescaler, PWM counter and fade tick live here; channels are replicated.
// Build option: LED_FADE_GAMMA_EN (see led_fade_channel) selects square-law duty.
module led_fade_driver
  import led_pkg::*;
#(
  parameter int unsigned N_LEDS   = LED_N_LEDS,
  parameter int unsigned PWM_BITS = LED_PWM_BITS,
  parameter int unsigned PWM_DIV  = LED_PWM_DIV,
  parameter int unsigned FADE_DIV = LED_FADE_DIV
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_LEDS-1:0]   i_pattern,
  input  logic                i_enable,
  input  logic [PWM_BITS-1:0] i_brightness,
  output logic [N_LEDS-1:0]   o_led,
  output logic                o_idle
);

  localparam int unsigned PRESC_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int unsigned FADE_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PWM_DIV - 1);
  localparam logic [FADE_W-1:0]  FADE_MAX  = FADE_W'(FADE_DIV - 1);

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [FADE_W-1:0]   fade_q, fade_d;
  logic                presc_wrap;
  logic                fade_tick;
  logic                idle_q;
  logic [N_LEDS-1:0]   match;
  logic [PWM_BITS-1:0] target [N_LEDS];

  assign presc_wrap = (presc_q == PRESC_MAX);
  assign fade_tick  = (fade_q == FADE_MAX);

  // Free-running counters; pwm_cnt wraps naturally at its width.
  always_comb begin
    presc_d = presc_wrap ? '0 : presc_q + PRESC_W'(1);
    pwm_d   = presc_wrap ? pwm_q + PWM_BITS'(1) : pwm_q;
    fade_d  = fade_tick ? '0 : fade_q + FADE_W'(1);
  end

  // Counter and idle registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      presc_q <= '0;
      pwm_q   <= '0;
      fade_q  <= '0;
      idle_q  <= 1'b1;
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      fade_q  <= fade_d;
      idle_q  <= &match;
    end
  end

  // Target mux: unlit or disabled channels fade toward zero.
  always_comb begin
    for (int i = 0; i < N_LEDS; i++) begin
      target[i] = (i_enable && i_pattern[i]) ? i_brightness : '0;
    end
  end

  for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_target    (target[gi]),
      .i_fade_tick (fade_tick),
      .i_pwm_cnt   (pwm_q),
      .o_led       (o_led[gi]),
      .o_match     (match[gi])
    );
  end

  assign o_idle = idle_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Self-checking bench for led_fade_driver with PWM_DIV=1, FADE_DIV=4.
module tb_led_fade_driver;

  localparam int N  = 16;
  localparam int PD = 1;
  localparam int FD = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_pattern;
  logic        i_enable;
  logic [7:0]  i_brightness;
  logic [15:0] o_led;
  logic        o_idle;

  always #5 i_clk = ~i_clk;

  led_fade_driver #(
    .N_LEDS   (N),
    .PWM_BITS (8),
    .PWM_DIV  (PD),
    .FADE_DIV (FD)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_pattern    (i_pattern),
    .i_enable     (i_enable),
    .i_brightness (i_brightness),
    .o_led        (o_led),
    .o_idle       (o_idle)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] led;
    logic        idle;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [15:0] pat;
    logic        en;
    logic [7:0]  br;
    int          cycles;
    logic        exp_idle;
  } vec_t;

  // Reference model state.
  int m_lvl[N];
  int m_pwm, m_presc, m_fade;

  function automatic int m_duty(input int lvl);
`ifdef LED_FADE_GAMMA_EN
    return (lvl * lvl) >> 8;
`else
    return lvl;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_lvl[i] = 0;
    m_pwm   = 0;
    m_presc = 0;
    m_fade  = 0;
  endtask

  // Predict the next edge from the model, push it, clock, then pop and compare.
  task automatic step();
    exp_t e;
    int   tgt;
    bit   tick;
    if (i_rst) begin
      e.led  = '0;
      e.idle = 1'b1;
    end else begin
      e.idle = 1'b1;
      tick   = (m_fade == FD - 1);
      for (int i = 0; i < N; i++) begin
        tgt = (i_enable && i_pattern[i]) ? int'(i_brightness) : 0;
        e.led[i] = (m_duty(m_lvl[i]) > m_pwm);
        if (m_lvl[i] != tgt) e.idle = 1'b0;
        if (m_lvl[i] < tgt) m_lvl[i] = tgt;
        else if (m_lvl[i] > tgt && tick) m_lvl[i] = m_lvl[i] - 1;
      end
      if (m_presc == PD - 1) begin
        m_presc = 0;
        m_pwm   = (m_pwm + 1) % 256;
      end else begin
        m_presc = m_presc + 1;
      end
      m_fade = tick ? 0 : m_fade + 1;
    end
    sb_q.push_back(e);
    @(posedge i_clk);
    #1;
    e = sb_q.pop_front();
    check("led", int'(o_led), int'(e.led));
    check("idle", int'(o_idle), int'(e.idle));
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Count high cycles of one channel over a full 256-step PWM frame.
  task automatic count_frame(input int ch, output int hi);
    hi = 0;
    repeat (256) begin
      step();
      hi += int'(o_led[ch]);
    end
  endtask

  // Clock until o_idle rises or the budget runs out; n = cycles taken.
  task automatic wait_idle(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!o_idle && n < budget);
  endtask

  task automatic set_in(input logic [15:0] pat, input logic en, input logic [7:0] br);
    i_pattern    = pat;
    i_enable     = en;
    i_brightness = br;
  endtask

  vec_t vecs[9];
  int   hi, n, exp_hi;

  initial begin
    vecs[0] = '{16'h0000, 1'b1, 8'h80, 3,   1'b1};
    vecs[1] = '{16'h0001, 1'b1, 8'h80, 3,   1'b1};
    vecs[2] = '{16'h00F0, 1'b1, 8'h40, 3,   1'b0};
    vecs[3] = '{16'h00F0, 1'b0, 8'h40, 2,   1'b0};
    vecs[4] = '{16'h0000, 1'b0, 8'h00, 600, 1'b1};
    vecs[5] = '{16'hAAAA, 1'b1, 8'h20, 4,   1'b1};
    vecs[6] = '{16'hAAAA, 1'b1, 8'h30, 3,   1'b1};
    vecs[7] = '{16'hAAAA, 1'b1, 8'h10, 3,   1'b0};
    vecs[8] = '{16'h0000, 1'b1, 8'h00, 220, 1'b1};

    // Reset state.
    i_rst = 1'b1;
    set_in(16'h0000, 1'b1, 8'h00);
    model_reset();
    #2;
    check("rst_led", int'(o_led), 0);
    check("rst_idle", int'(o_idle), 1);
    steps(2);
    i_rst = 1'b0;
    steps(5);
    check("idle_after_rst", int'(o_idle), 1);

    // Table-driven vectors.
    for (int v = 0; v < 9; v++) begin
      set_in(vecs[v].pat, vecs[v].en, vecs[v].br);
      steps(vecs[v].cycles);
      check($sformatf("vec%0d_idle", v), int'(o_idle), int'(vecs[v].exp_idle));
    end

    // Half brightness duty on channel 0.
    set_in(16'h0001, 1'b1, 8'h80);
    steps(3);
`ifdef LED_FADE_GAMMA_EN
    exp_hi = 64;
`else
    exp_hi = 128;
`endif
    count_frame(0, hi);
    check("duty_0x80", hi, exp_hi);

    // Full linear fade from 0x80: 128 ticks of 4 cycles, plus the idle register.
    set_in(16'h0000, 1'b1, 8'h80);
    wait_idle(600, n);
    check("fade_0x80_time_ok", int'(n >= 505 && n <= 516), 1);

    // Re-rise on a fade-tick cycle: attack wins, level lands exactly on target.
    set_in(16'h0001, 1'b1, 8'h80);
    steps(3);
    set_in(16'h0000, 1'b1, 8'h80);
    steps(10);
    n = 0;
    while (m_fade != FD - 1 && n < 8) begin
      step();
      n++;
    end
    check("tick_aligned", m_fade, FD - 1);
    set_in(16'h0001, 1'b1, 8'h80);
    steps(2);
    check("attack_wins_idle", int'(o_idle), 1);
    count_frame(0, hi);
    check("attack_wins_duty", hi, exp_hi);

    // All channels full, then disable: all decay together.
    set_in(16'hFFFF, 1'b1, 8'hFF);
    steps(3);
    check("all_on_idle", int'(o_idle), 1);
    count_frame(15, hi);
`ifdef LED_FADE_GAMMA_EN
    check("duty_0xff", hi, 254);
`else
    check("duty_0xff", hi, 255);
`endif
    i_enable = 1'b0;
    wait_idle(1100, n);
    check("disable_fade_time_ok", int'(n >= 1015 && n <= 1025), 1);
    check("disable_led_off", int'(o_led), 0);

    // Low levels: gamma rounds 0x10 to 1 and 0x0F to 0.
    set_in(16'h0001, 1'b1, 8'h10);
    steps(3);
    count_frame(0, hi);
`ifdef LED_FADE_GAMMA_EN
    check("duty_0x10", hi, 1);
`else
    check("duty_0x10", hi, 16);
`endif
    i_brightness = 8'h0F;
    steps(8);
    count_frame(0, hi);
`ifdef LED_FADE_GAMMA_EN
    check("duty_0x0f", hi, 0);
`else
    check("duty_0x0f", hi, 15);
`endif

    // Asynchronous reset in the middle of a fade.
    set_in(16'h0001, 1'b1, 8'hFF);
    steps(3);
    i_pattern = 16'h0000;
    steps(20);
    check("midfade_busy", int'(o_idle), 0);
    #2;
    i_rst = 1'b1;
    model_reset();
    #1;
    check("midfade_rst_led", int'(o_led), 0);
    check("midfade_rst_idle", int'(o_idle), 1);
    step();
    i_rst = 1'b0;
    steps(5);
    check("post_rst_idle", int'(o_idle), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
